// File: rtl/router_pkt_reg.sv
// Router packet register: header/payload/check-byte capture, running checksum,
// length check, and a small hold buffer that absorbs bytes while the output FIFO is full.
module router_pkt_reg #(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 6,
   parameter int HOLD_DEPTH = 2,
   parameter int CHK_MODE   = 0,
   localparam int CW = $clog2(HOLD_DEPTH + 1),
   localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              dout_wr,
   output logic [CW-1:0]     hold_count,
   output logic              hold_empty,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err,
   output logic              len_err,
   output logic              ovf_err
);

   logic [DATA_W-1:0]                 hdr_q, acc_q, chk_q;
   logic [LEN_W-1:0]                  cnt_q;
   logic                              chk_eval_q;
   logic [HOLD_DEPTH-1:0][DATA_W-1:0] hold_q;
   logic [PW-1:0]                     head_q, tail_q;

   logic ld_take, direct, hold_full, do_pop;

   function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (CHK_MODE == 0) ? (a ^ b) : (a + b);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(HOLD_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign hold_empty = (hold_count == '0);
   assign hold_full  = (hold_count == CW'(HOLD_DEPTH));
   assign ld_take    = !lfd_state && ld_state;
   // Bypass the hold buffer only when it is empty, otherwise byte order would break.
   assign direct     = ld_take && !fifo_full && hold_empty;
   assign do_pop     = !lfd_state && !ld_state && laf_state && !fifo_full && !hold_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         dout          <= '0;
         dout_wr       <= 1'b0;
         hold_count    <= '0;
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
         err           <= 1'b0;
         len_err       <= 1'b0;
         ovf_err       <= 1'b0;
         hdr_q         <= '0;
         acc_q         <= '0;
         chk_q         <= '0;
         cnt_q         <= '0;
         chk_eval_q    <= 1'b0;
         hold_q        <= '0;
         head_q        <= '0;
         tail_q        <= '0;
      end else begin
         dout_wr <= 1'b0;

         if (lfd_state) begin
            dout    <= hdr_q;
            dout_wr <= 1'b1;
            acc_q   <= fold(acc_q, hdr_q);
         end else if (ld_state) begin
            if (pkt_valid) begin
               if (!full_state) begin
                  acc_q <= fold(acc_q, data_in);
                  if (cnt_q != '1) cnt_q <= cnt_q + LEN_W'(1);
               end
            end else begin
               chk_q       <= data_in;
               parity_done <= 1'b1;
            end
            if (direct) begin
               dout    <= data_in;
               dout_wr <= 1'b1;
            end else if (!hold_full) begin
               hold_q[tail_q] <= data_in;
               tail_q         <= ptr_inc(tail_q);
               hold_count     <= hold_count + CW'(1);
            end else begin
               ovf_err <= 1'b1;
            end
         end else if (do_pop) begin
            dout       <= hold_q[head_q];
            dout_wr    <= 1'b1;
            head_q     <= ptr_inc(head_q);
            hold_count <= hold_count - CW'(1);
         end

         if (ld_take && !pkt_valid) low_pkt_valid <= 1'b1;
         else if (rst_int_reg)      low_pkt_valid <= 1'b0;

         // Evaluate once, on the first edge that sees parity_done, then hold.
         if (parity_done && !chk_eval_q) begin
            err        <= (acc_q != chk_q);
            len_err    <= (cnt_q != hdr_q[LEN_W+1:2]);
            chk_eval_q <= 1'b1;
         end

         if (detect_add && pkt_valid) begin
            hdr_q       <= data_in;
            acc_q       <= '0;
            cnt_q       <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
            ovf_err     <= 1'b0;
            chk_eval_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Scoreboard bench for router_pkt_reg: XOR-parity and additive-checksum instances
// driven in lockstep; dout is checked by a monitor popping per-instance queues.
module tb_router_pkt_reg;

   logic       clk = 1'b0;
   logic       reset, pkt_valid, fifo_full;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [7:0] data_in;

   logic [7:0] dout        [2];
   logic       dout_wr     [2];
   logic [1:0] hold_count  [2];
   logic       hold_empty  [2];
   logic       parity_done [2];
   logic       low_pkt_valid [2];
   logic       err         [2];
   logic       len_err     [2];
   logic       ovf_err     [2];

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   router_pkt_reg #(.DATA_W(8), .LEN_W(6), .HOLD_DEPTH(2), .CHK_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .dout(dout[0]), .dout_wr(dout_wr[0]),
      .hold_count(hold_count[0]), .hold_empty(hold_empty[0]),
      .parity_done(parity_done[0]), .low_pkt_valid(low_pkt_valid[0]),
      .err(err[0]), .len_err(len_err[0]), .ovf_err(ovf_err[0]));

   router_pkt_reg #(.DATA_W(8), .LEN_W(6), .HOLD_DEPTH(2), .CHK_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .dout(dout[1]), .dout_wr(dout_wr[1]),
      .hold_count(hold_count[1]), .hold_empty(hold_empty[1]),
      .parity_done(parity_done[1]), .low_pkt_valid(low_pkt_valid[1]),
      .err(err[1]), .len_err(len_err[1]), .ovf_err(ovf_err[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every dout write must match the head of that instance's queue.
   initial forever begin
      @(negedge clk);
      if (dout_wr[0] === 1'b1) begin
         if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dout0_unexpected: got %0h expected no write", dout[0]);
         end else chk("dout0", {24'h0, dout[0]}, {24'h0, q0.pop_front()});
      end
      if (dout_wr[1] === 1'b1) begin
         if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dout1_unexpected: got %0h expected no write", dout[1]);
         end else chk("dout1", {24'h0, dout[1]}, {24'h0, q1.pop_front()});
      end
   end

   task automatic expect_out(input logic [7:0] b);
      q0.push_back(b);
      q1.push_back(b);
   endtask

   task automatic cyc(input logic da, input logic lfd, input logic ld, input logic laf,
                      input logic pv, input logic ff, input logic [7:0] d);
      detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
      pkt_valid = pv; fifo_full = ff; data_in = d;
      @(posedge clk); #1;
      detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
      pkt_valid = 0; fifo_full = 0; rst_int_reg = 0;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   // Header, three payload bytes and check byte, all forwarded directly.
   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] p0,
                           input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] ck);
      cyc(1, 0, 0, 0, 1, 0, hdr);
      expect_out(hdr); cyc(0, 1, 0, 0, 1, 0, hdr);
      expect_out(p0);  cyc(0, 0, 1, 0, 1, 0, p0);
      expect_out(p1);  cyc(0, 0, 1, 0, 1, 0, p1);
      expect_out(p2);  cyc(0, 0, 1, 0, 1, 0, p2);
      expect_out(ck);  cyc(0, 0, 1, 0, 0, 0, ck);
   endtask

   task automatic check_verdict(input string tag, input logic e0, input logic l0,
                                input logic e1, input logic l1);
      chk({tag, "_pdone0"}, parity_done[0], 1);
      chk({tag, "_err0_pre"}, err[0], 0);
      idle();
      chk({tag, "_err0"}, err[0], e0);
      chk({tag, "_len0"}, len_err[0], l0);
      chk({tag, "_err1"}, err[1], e1);
      chk({tag, "_len1"}, len_err[1], l1);
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_dout"}, dout[d], 0);
         chk({tag, "_dout_wr"}, dout_wr[d], 0);
         chk({tag, "_hold_count"}, hold_count[d], 0);
         chk({tag, "_hold_empty"}, hold_empty[d], 1);
         chk({tag, "_pdone"}, parity_done[d], 0);
         chk({tag, "_lowpv"}, low_pkt_valid[d], 0);
         chk({tag, "_flags"}, {err[d], len_err[d], ovf_err[d]}, 0);
      end
   endtask

   initial begin
      reset = 0; rst_int_reg = 0; full_state = 0;
      detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
      pkt_valid = 0; fifo_full = 0; data_in = 8'h00;
      idle(); idle();
      check_zero("reset");
      reset = 1;

      // Good packet: XOR 0x0D matches, additive sum is 0x73 so check 0x0D is wrong there.
      send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
      chk("lowpv_set", low_pkt_valid[0], 1);
      check_verdict("pktA", 0, 0, 1, 0);
      rst_int_reg = 1; idle();
      chk("lowpv_clr", low_pkt_valid[0], 0);

      send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E);
      check_verdict("bad_chk", 1, 0, 1, 0);

      send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h73);
      check_verdict("sum_chk", 1, 0, 0, 0);

      // Header length 4 but only 3 payload bytes.
      send_pkt(8'h11, 8'h11, 8'h22, 8'h33, 8'h11);
      check_verdict("len", 0, 1, 1, 1);

      // Hold buffer fill, overflow drop, then drain in order.
      cyc(1, 0, 0, 0, 1, 0, 8'h0D);
      expect_out(8'h0D); cyc(0, 1, 0, 0, 1, 0, 8'h0D);
      expect_out(8'h11); cyc(0, 0, 1, 0, 1, 0, 8'h11);
      cyc(0, 0, 1, 0, 1, 1, 8'h22);
      cyc(0, 0, 1, 0, 1, 1, 8'h33);
      chk("ovf_not_yet", ovf_err[0], 0);
      cyc(0, 0, 1, 0, 1, 1, 8'h44);
      chk("hold_count_full", hold_count[0], 2);
      chk("hold_empty_full", hold_empty[0], 0);
      chk("ovf_err", ovf_err[0], 1);
      expect_out(8'h22); cyc(0, 0, 0, 1, 1, 0, 8'h55);
      chk("hold_count_one", hold_count[0], 1);
      expect_out(8'h33); cyc(0, 0, 0, 1, 1, 0, 8'h55);
      chk("hold_empty_drained", hold_empty[0], 1);
      chk("hold_count_drained", hold_count[0], 0);
      cyc(0, 0, 0, 1, 1, 0, 8'h55);
      chk("dout_held", dout[0], 8'h33);
      chk("dout_wr_idle", dout_wr[0], 0);

      // Reset mid-packet with one byte sitting in the hold buffer.
      cyc(1, 0, 0, 0, 1, 0, 8'h0D);
      expect_out(8'h0D); cyc(0, 1, 0, 0, 1, 0, 8'h0D);
      expect_out(8'h11); cyc(0, 0, 1, 0, 1, 0, 8'h11);
      cyc(0, 0, 1, 0, 1, 1, 8'h22);
      chk("held_before_reset", hold_count[0], 1);
      reset = 0; idle();
      check_zero("mid_reset");
      reset = 1;
      send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
      check_verdict("post_reset", 0, 0, 1, 0);

      idle(); idle();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
